// File: rtl/param_cache_pkg.sv
// Shared types and helpers for the parametrised cache data array.
// Holds the fill-engine state encoding and the byte-lane merge used by every write/forward path.
package param_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } fill_state_e;

    // Widest line the merge helper supports; callers zero-extend into it and truncate the result.
    localparam int MAX_LINE_BITS = 1024;
    localparam int MAX_BYTES     = MAX_LINE_BITS / 8;

    // Byte-wise select: lanes with sel set take 'over', all others keep 'base'.
    function automatic logic [MAX_LINE_BITS-1:0] byte_merge(
        input logic [MAX_LINE_BITS-1:0] base,
        input logic [MAX_LINE_BITS-1:0] over,
        input logic [MAX_BYTES-1:0]     sel
    );
        logic [MAX_LINE_BITS-1:0] res;
        res = base;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (sel[b]) res[b*8 +: 8] = over[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/param_fill_buffer.sv
// Line-fill engine: collects memory beats into a line buffer and tracks bytes
// stored by the CPU into the target line while the fill is in flight.
module param_fill_buffer
    import param_cache_pkg::*;
#(
    parameter int SETS      = 8,
    parameter int WAYS      = 2,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fill_start,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] fill_index,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] fill_way,
    input  logic                          beat_valid,
    input  logic [BEAT_BITS-1:0]          beat_data,
    input  logic                          wr_en,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] wr_index,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] wr_way,
    input  logic [LINE_BITS/8-1:0]        wr_byte_en,
    output logic [LINE_BITS-1:0]          line,
    output logic [LINE_BITS/8-1:0]        mask,
    output logic                          commit,
    output logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] index,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] way,
    output logic                          busy
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    fill_state_e                       state_q, state_d;
    logic [BW-1:0]                     beat_count;
    logic [BEATS-1:0][BEAT_BITS-1:0]   beats;
    logic                              last_beat;
    logic                              wr_hit;

    assign last_beat = (beat_count == BW'(BEATS - 1));
    assign wr_hit    = wr_en && (wr_index == index) && (wr_way == way);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: next state defaults to the current state first, so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_start) state_d = COLLECT;
            COLLECT: if (beat_valid && last_beat) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
            mask       <= '0;
            index      <= '0;
            way        <= '0;
        end else begin
            if (state_q == IDLE && fill_start) begin
                index      <= fill_index;
                way        <= fill_way;
                beat_count <= '0;
                mask       <= '0;
            end
            if (state_q == COLLECT && beat_valid) beat_count <= beat_count + BW'(1);
            if ((state_q == COLLECT || state_q == COMMIT) && wr_hit) mask <= mask | wr_byte_en;
        end
    end

    // Beat data needs no reset: it is only committed after being fully rewritten.
    always_ff @(posedge clk) begin
        if (state_q == COLLECT && beat_valid) beats[beat_count] <= beat_data;
    end

    assign line   = beats;
    assign commit = (state_q == COMMIT);
    assign busy   = (state_q != IDLE);

endmodule

// File: rtl/param_fill_data_array.sv
// Multi-way cache data array with byte-enabled stores, a write-first registered
// read port and an integrated burst line-fill engine.
module param_fill_data_array
    import param_cache_pkg::*;
#(
    parameter int SETS      = 8,
    parameter int WAYS      = 2,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] rd_index,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] rd_way,
    output logic [LINE_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          wr_en,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] wr_index,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] wr_way,
    input  logic [LINE_BITS/8-1:0]        wr_byte_en,
    input  logic [LINE_BITS-1:0]          wr_data,
    input  logic                          fill_start,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] fill_index,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] fill_way,
    input  logic                          beat_valid,
    input  logic [BEAT_BITS-1:0]          beat_data,
    output logic                          fill_busy,
    output logic                          fill_done
);

    localparam int BYTES = LINE_BITS / 8;
    localparam int IW    = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [LINE_BITS-1:0] mem [SETS][WAYS];

    logic [LINE_BITS-1:0] fill_line;
    logic [BYTES-1:0]     fill_mask;
    logic                 commit;
    logic [IW-1:0]        f_index;
    logic [WW-1:0]        f_way;

    logic [LINE_BITS-1:0] commit_line;
    logic [LINE_BITS-1:0] wr_base;
    logic [LINE_BITS-1:0] store_line;
    logic [LINE_BITS-1:0] rd_line;
    logic                 commit_hits_wr;

    param_fill_buffer #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_fill (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_index (fill_index),
        .fill_way   (fill_way),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_way     (wr_way),
        .wr_byte_en (wr_byte_en),
        .line       (fill_line),
        .mask       (fill_mask),
        .commit     (commit),
        .index      (f_index),
        .way        (f_way),
        .busy       (fill_busy)
    );

    assign fill_done      = commit;
    assign commit_hits_wr = commit && (f_index == wr_index) && (f_way == wr_way);

    // Priority per byte is store over commit over array; the store path builds on the commit result.
    always_comb begin
        commit_line = LINE_BITS'(byte_merge(MAX_LINE_BITS'(fill_line),
                                            MAX_LINE_BITS'(mem[f_index][f_way]),
                                            MAX_BYTES'(fill_mask)));
        wr_base     = commit_hits_wr ? commit_line : mem[wr_index][wr_way];
        store_line  = LINE_BITS'(byte_merge(MAX_LINE_BITS'(wr_base),
                                            MAX_LINE_BITS'(wr_data),
                                            MAX_BYTES'(wr_byte_en)));
        rd_line = mem[rd_index][rd_way];
        if (commit && (f_index == rd_index) && (f_way == rd_way)) rd_line = commit_line;
        if (wr_en && (wr_index == rd_index) && (wr_way == rd_way)) rd_line = store_line;
    end

    // NOTE: the array must clear on reset, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) mem[s][w] <= '0;
            end
        end else begin
            if (commit) mem[f_index][f_way] <= commit_line;
            if (wr_en)  mem[wr_index][wr_way] <= store_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_line;
        end
    end

endmodule

// File: doc/param_fill_data_array.md
# param_fill_data_array

Parametrised multi-way cache data array with byte-enabled CPU writes, a registered write-first read port, and an integrated burst line-fill engine. Sits between the cache control FSM and the memory/arbiter port: the controller issues hits, stores, and line fills, and the block assembles fill beats and merges them with bytes stored while the fill was in flight.

## Interface
Parameters:
- SETS, 8, number of sets (power of 2, ≥2)
- WAYS, 2, associativity (power of 2, ≥1)
- LINE_BITS, 256, line width (multiple of 8 and of BEAT_BITS)
- BEAT_BITS, 64, memory burst beat width; BEATS = LINE_BITS/BEAT_BITS ≥1
- Derived localparams: BYTES = LINE_BITS/8, IW = max(1,$clog2(SETS)), WW = max(1,$clog2(WAYS)), BW = max(1,$clog2(BEATS))

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_en  in  1  read request
- rd_index  in  IW  read set
- rd_way  in  WW  read way
- rd_data  out  LINE_BITS  registered read data
- rd_valid  out  1  rd_data valid (one cycle after rd_en)
- wr_en  in  1  CPU store strobe
- wr_index  in  IW  store set
- wr_way  in  WW  store way
- wr_byte_en  in  BYTES  per-byte write enable
- wr_data  in  LINE_BITS  store data (byte-aligned lanes)
- fill_start  in  1  begin line fill
- fill_index  in  IW  fill set
- fill_way  in  WW  fill way
- beat_valid  in  1  memory beat present
- beat_data  in  BEAT_BITS  memory beat, beat 0 = line bits [BEAT_BITS-1:0]
- fill_busy  out  1  fill engine not IDLE
- fill_done  out  1  one-cycle pulse in COMMIT cycle

## Operation
- Storage: SETS×WAYS lines of LINE_BITS; all cleared to 0 on rst.
- CPU store: when wr_en, each byte b with wr_byte_en[b] writes wr_data byte b into [wr_index][wr_way]; other bytes keep their values.
- Read: rd_en in cycle T samples line [rd_index][rd_way] write-first, including a CPU store and a fill commit in cycle T, byte by byte (store over commit over array). Result registered at T+1 with rd_valid=1. With rd_en=0, rd_valid=0 and rd_data holds its value.
- Fill FSM states:
  - IDLE: fill_start → latch index/way, clear beat count and merge mask, go to COLLECT.
  - COLLECT: each beat_valid writes beat_data to buffer slot beat_count and increments the count. On the BEATS-th beat, go to COMMIT.
  - COMMIT: for one cycle, write the full line to [fill_index][fill_way]. Bytes set in the merge mask keep their array value. fill_done=1, then return to IDLE.
- Merge mask: in COLLECT and COMMIT, a CPU store hitting the latched index/way ORs wr_byte_en into the mask. In the COMMIT cycle, the same-cycle store bytes win over fill bytes.
- fill_start outside IDLE: ignored. beat_valid outside COLLECT: ignored.
- Stores and reads to other lines proceed normally during a fill.
- Simultaneous store and commit to different lines: both complete.

## Timing
- Reset values: rd_data=0, rd_valid=0, fill_busy=0, fill_done=0, FSM=IDLE, beat count=0, mask=0.
- rst mid-fill: aborts to IDLE, no fill_done, nothing committed.
- Read latency: 1 cycle. Store visible to a same-cycle read (forwarded) and to all later reads.
- Fill latency: fill_start at T, beats at T+1.., last beat at L → COMMIT at L+1 (fill_done=1), IDLE at L+2. fill_busy is high from T+1 through L+1.
- A read of the filled line at L+1 returns the merged line at L+2.
- BEATS=1: one beat → COMMIT the next cycle.

## Structure
- Package param_cache_pkg holds:
  - fill_state_e {IDLE, COLLECT, COMMIT}
  - byte-merge helper function (mask-select of two lines)
- Sub-module param_fill_buffer holds:
  - beat counter
  - BEATS×BEAT_BITS buffer
  - merge mask
  - FSM

  It exports line, mask, commit strobe, and latched index/way. The top level holds the array, forwarding muxes, and read register.

## Test plan
- Reset, then read all 8 sets × 2 ways → every rd_data = 0, each rd_valid one cycle after its rd_en.
- Store bytes 0–3 = 0xDEADBEEF to set 3 way 1 while reading it in the same cycle → rd_data[31:0]=0xDEADBEEF at next cycle, remaining bytes 0.
- Fill set 5 way 0 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444… (gaps between beats allowed) → fill_done one cycle after beat 4; read returns the concatenation, beat 0 in the LSBs.
- During that fill, store byte 0 = 0xAB to set 5 way 0 after beat 2, and store to set 5 way 1 in the COMMIT cycle → byte 0 reads 0xAB, the rest fill data; way 1 holds the store.
- Assert rst after two beats → fill_busy=0, no fill_done, line stays 0. A second fill_start while busy is ignored.
